pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_if.sv | 28 ++
 rtl/pipe_skid_reg.sv | 83 ++++++++
 tb/tb_pipe_skid_reg.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream offer side
// and downstream head side of the buffer.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [EXC_W-1:0]  in_exc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [EXC_W-1:0]  out_exc;
  logic              out_exc_any;

  // Environment side: offers entries and takes the head.
  modport master (
    output in_valid, in_data, in_exc, out_ready,
    input  in_ready, out_valid, out_data, out_exc, out_exc_any
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_data, in_exc, out_ready,
    output in_ready, out_valid, out_data, out_exc, out_exc_any
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Registered pipeline buffer: small circular FIFO of {data, exc}
// entries with flush, occupancy and saturating flush accounting.
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 9,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  pipe_skid_reg_if.slave           bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               flushed_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [EXC_W-1:0]  exc_mem  [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [8:0]        fl_sum;
  logic [7:0]        fl_next;

  // in_ready depends only on stored occupancy, never on out_ready/flush.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign push = bus.in_valid && !full && !flush;
  assign pop  = !empty && bus.out_ready && !flush;

  assign bus.in_ready    = !full;
  assign bus.out_valid   = !empty;
  assign bus.out_data    = data_mem[rd_ptr];
  assign bus.out_exc     = exc_mem[rd_ptr];
  assign bus.out_exc_any = !empty && (exc_mem[rd_ptr] != '0);

  // Flush accounting adds the entries held at the edge, capped at 255.
  assign fl_sum  = {1'b0, flushed_cnt} + 9'(count);
  assign fl_next = fl_sum[8] ? 8'hff : fl_sum[7:0];

  // Storage writes; reset clears every entry so outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        exc_mem[i]  <= '0;
      end
    end else if (push) begin
      data_mem[wr_ptr] <= bus.in_data;
      exc_mem[wr_ptr]  <= bus.in_exc;
    end
  end

  // Pointer and occupancy update; flush wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Saturating count of entries discarded by flush (not by reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        flushed_cnt <= '0;
    else if (flush) flushed_cnt <= fl_next;
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg against a queue-based
// reference model of the buffer behaviour.
module tb_pipe_skid_reg;
  localparam int DATA_W = 32;
  localparam int EXC_W  = 9;
  localparam int DEPTH  = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk = 0;
  logic          rst = 1;
  logic          flush = 0;
  logic [CW-1:0] count;
  logic [7:0]    flushed_cnt;

  pipe_skid_reg_if #(.DATA_W(DATA_W), .EXC_W(EXC_W)) bus ();

  pipe_skid_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave),
    .count(count), .flushed_cnt(flushed_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [EXC_W-1:0]  e;
  } ent_t;

  ent_t m_q[$];
  int   m_fl = 0;

  // Apply inputs, advance one edge, update model, land on the negedge.
  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic [EXC_W-1:0] e, input logic r,
                       input logic f);
    bit do_pop, do_push;
    ent_t x;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_exc    = e;
    bus.out_ready = r;
    flush         = f;
    @(posedge clk);
    if (f) begin
      m_fl = m_fl + m_q.size();
      if (m_fl > 255) m_fl = 255;
      m_q.delete();
    end else begin
      do_pop  = (m_q.size() != 0) && r;
      do_push = v && (m_q.size() < DEPTH);
      if (do_pop) void'(m_q.pop_front());
      x.d = d;
      x.e = e;
      if (do_push) m_q.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (count !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs got cnt=%0d ov=%b ir=%b want 0 0 1",
               count, bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.out_data !== '0 || bus.out_exc !== '0 || bus.out_exc_any !== 1'b0
        || flushed_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_data got d=%h e=%h any=%b fl=%0d want zeros",
               bus.out_data, bus.out_exc, bus.out_exc_any, flushed_cnt);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    drive(1, 32'h11, 0, 0, 0);
    drive(1, 32'h22, 0, 0, 0);
    checks++;
    if (count !== CW'(2) || bus.in_ready !== 1'b0 || bus.out_data !== 32'h11) begin
      errors++;
      $display("FAIL fill got cnt=%0d ir=%b d=%h want 2 0 11",
               count, bus.in_ready, bus.out_data);
    end
    drive(1, 32'h33, 0, 0, 0);
    checks++;
    if (count !== CW'(2) || bus.out_data !== 32'h11) begin
      errors++;
      $display("FAIL fill_third got cnt=%0d d=%h want 2 11",
               count, bus.out_data);
    end
  endtask

  task automatic test_full_pop();
    drive(1, 32'h33, 0, 1, 0);
    checks++;
    if (count !== CW'(1) || bus.in_ready !== 1'b1 || bus.out_data !== 32'h22) begin
      errors++;
      $display("FAIL full_pop got cnt=%0d ir=%b d=%h want 1 1 22",
               count, bus.in_ready, bus.out_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) begin
      drive(1, DATA_W'(i), 0, 1, 0);
      checks++;
      if (count !== CW'(1) || bus.out_data !== DATA_W'(i)
          || bus.out_data !== m_q[0].d) begin
        errors++;
        $display("FAIL b2b_%0d got cnt=%0d d=%h want 1 %h",
                 i, count, bus.out_data, i);
      end
    end
  endtask

  task automatic test_flush();
    drive(1, 32'h6, 0, 0, 0);
    drive(1, 32'h7, 0, 0, 1);
    checks++;
    if (count !== '0 || bus.out_valid !== 1'b0 || flushed_cnt !== 8'd2) begin
      errors++;
      $display("FAIL flush_one got cnt=%0d ov=%b fl=%0d want 0 0 2",
               count, bus.out_valid, flushed_cnt);
    end
    for (int i = 0; i < 129; i++) begin
      drive(1, $urandom, 0, 0, 0);
      drive(1, $urandom, 0, 0, 0);
      drive(1, $urandom, 0, 0, 1);
      checks++;
      if (flushed_cnt !== 8'(m_fl) || count !== '0) begin
        errors++;
        $display("FAIL flush_rep_%0d got fl=%0d cnt=%0d want %0d 0",
                 i, flushed_cnt, count, m_fl);
      end
    end
    checks++;
    if (flushed_cnt !== 8'd255) begin
      errors++;
      $display("FAIL flush_sat got %0d want 255", flushed_cnt);
    end
  endtask

  task automatic test_exc();
    drive(1, 32'h44, 9'b000010000, 0, 0);
    checks++;
    if (bus.out_exc_any !== 1'b1 || bus.out_exc !== 9'b000010000) begin
      errors++;
      $display("FAIL exc_set got any=%b e=%b want 1 000010000",
               bus.out_exc_any, bus.out_exc);
    end
    drive(0, 0, 0, 1, 0);
    checks++;
    if (bus.out_exc_any !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL exc_pop got any=%b ov=%b want 0 0",
               bus.out_exc_any, bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 32'haa, 9'h1, 0, 0);
    drive(1, 32'hbb, 9'h2, 0, 0);
    bus.in_valid = 0;
    #2;
    rst = 1;
    #1;
    m_q.delete();
    m_fl = 0;
    checks++;
    if (bus.out_valid !== 1'b0 || flushed_cnt !== 8'd0 || bus.in_ready !== 1'b1
        || count !== '0) begin
      errors++;
      $display("FAIL async_rst got ov=%b fl=%0d ir=%b cnt=%0d want 0 0 1 0",
               bus.out_valid, flushed_cnt, bus.in_ready, count);
    end
    #1;
    rst = 0;
    drive(1, 32'h55, 0, 0, 0);
    checks++;
    if (count !== CW'(1) || bus.out_data !== 32'h55) begin
      errors++;
      $display("FAIL post_rst got cnt=%0d d=%h want 1 55",
               count, bus.out_data);
    end
  endtask

  task automatic test_random();
    logic [EXC_W-1:0] e;
    logic exp_any;
    for (int i = 0; i < 500; i++) begin
      e = ($urandom_range(0, 2) == 0) ? EXC_W'($urandom) : '0;
      drive($urandom_range(0, 3) != 0, $urandom, e,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      exp_any = (m_q.size() != 0) && (m_q[0].e != '0);
      checks++;
      if (count !== CW'(m_q.size()) || bus.in_ready !== (m_q.size() < DEPTH)
          || bus.out_valid !== (m_q.size() != 0)
          || bus.out_exc_any !== exp_any || flushed_cnt !== 8'(m_fl)) begin
        errors++;
        $display("FAIL rand_%0d got cnt=%0d ir=%b ov=%b any=%b fl=%0d want cnt=%0d any=%b fl=%0d",
                 i, count, bus.in_ready, bus.out_valid, bus.out_exc_any,
                 flushed_cnt, m_q.size(), exp_any, m_fl);
      end
      if (m_q.size() != 0) begin
        checks++;
        if (bus.out_data !== m_q[0].d || bus.out_exc !== m_q[0].e) begin
          errors++;
          $display("FAIL rand_head_%0d got %h/%h want %h/%h",
                   i, bus.out_data, bus.out_exc, m_q[0].d, m_q[0].e);
        end
      end
    end
  endtask

  initial begin
    bus.in_valid  = 0;
    bus.in_data   = '0;
    bus.in_exc    = '0;
    bus.out_ready = 0;
    test_reset();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_flush();
    test_exc();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
